// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Define TIMER_AUTORELOAD_EN to make MODE=01 auto-reload; otherwise every mode is one-shot.
module timer_dev #(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, CNT, INT} state_t;

`ifdef TIMER_AUTORELOAD_EN
  localparam logic AUTO_OK = 1'b1;
`else
  localparam logic AUTO_OK = 1'b0;
`endif

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic [1:0]  sel;
  logic        unused_addr;

  assign sel         = addr[3:2];
  assign unused_addr = ^addr[31:4];

  // MODE=1x falls back to one-shot, as does everything when auto-reload is compiled out
  function automatic logic reload_sel(input logic [1:0] m);
    return AUTO_OK && (m == 2'b01);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= RESET_PRESET;
      count    <= 32'h0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            count <= preset;
            state <= CNT;
          end
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'h0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          state <= IDLE;
          if (reload_sel(mode)) irq_flag <= 1'b0;
          else                  en       <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // CPU writes come last so they override the FSM's EN clear and flag set
      if (we) begin
        case (sel)
          2'd0: begin
            en       <= din[0];
            mode     <= din[2:1];
            im       <= din[3];
            irq_flag <= 1'b0;
          end
          2'd1: begin
            preset   <= din;
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dout = 32'h0;
    case (sel)
      2'd0:    dout = {28'h0, im, mode, en};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'h0;
    endcase
  end

  assign irq = irq_flag & im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: a vector table for single-edge register behaviour plus
// hand sequences for reset mid-count, CTRL write collision and the reload/one-shot period.
module tb_timer_dev;

  localparam logic [31:0] RP = 32'h0000_0007;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks;
  int failures;

  timer_dev #(.RESET_PRESET(RP)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [1:0]  roff;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[32];
  int   nv;

  task automatic add(input logic w, input logic [1:0] o, input logic [31:0] d,
                     input logic [1:0] ro, input logic [31:0] ed, input logic ei);
    vecs[nv].we       = w;
    vecs[nv].off      = o;
    vecs[nv].wdata    = d;
    vecs[nv].roff     = ro;
    vecs[nv].exp_dout = ed;
    vecs[nv].exp_irq  = ei;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one edge's inputs, then leave a read address settled for sampling
  task automatic step(input logic w, input logic [1:0] o, input logic [31:0] d,
                      input logic [1:0] ro);
    we   = w;
    addr = {28'h00007F0, o};
    din  = d;
    @(posedge clk);
    #1;
    we   = 1'b0;
    addr = {28'h00007F0, ro};
    #1;
  endtask

  initial begin
    int pulses;
    logic exp_irq;
    checks   = 0;
    failures = 0;
    nv       = 0;
    reset    = 1'b0;
    we       = 1'b0;
    din      = 32'h0;
    addr     = {28'h00007F0, 2'd0};

    // One-shot, PRESET=5
    add(1, 2'd1, 32'd5,        2'd1, 32'd5,        0);
    add(1, 2'd0, 32'h9,        2'd0, 32'h9,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd5,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd4,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd3,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd2,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd1,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd0,        1);
    add(0, 2'd0, 32'h0,        2'd0, 32'h8,        1);
    add(0, 2'd0, 32'h0,        2'd2, 32'd0,        1);
    add(1, 2'd0, 32'h8,        2'd0, 32'h8,        0);
    // Register map; the CTRL write sets EN so a load of PRESET=5 follows
    add(1, 2'd0, 32'hFFFFFFFF, 2'd0, 32'h0000000F, 0);
    add(1, 2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 0);
    add(1, 2'd2, 32'hFFFFFFFF, 2'd2, 32'd4,        0);
    add(1, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h0,        0);
    add(1, 2'd0, 32'h0,        2'd2, 32'd2,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd2,        0);
    // Masked interrupt, PRESET=2
    add(1, 2'd1, 32'd2,        2'd1, 32'd2,        0);
    add(1, 2'd0, 32'h1,        2'd0, 32'h1,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd2,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd1,        0);
    add(0, 2'd0, 32'h0,        2'd2, 32'd0,        0);
    add(0, 2'd0, 32'h0,        2'd0, 32'h0,        0);
    add(1, 2'd0, 32'h8,        2'd0, 32'h8,        0);

    // Reset values while reset is held
    #1 reset = 1'b1;
    #2;
    check("rst_ctrl", dout, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    addr = {28'h00007F0, 2'd1};
    #1 check("rst_preset", dout, RP);
    addr = {28'h00007F0, 2'd2};
    #1 check("rst_count", dout, 32'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;

    for (int i = 0; i < nv; i++) begin
      step(vecs[i].we, vecs[i].off, vecs[i].wdata, vecs[i].roff);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Reset mid-count, asserted between clock edges
    step(1, 2'd1, 32'd100, 2'd2);
    step(1, 2'd0, 32'h9, 2'd2);
    for (int k = 0; k < 10; k++) step(0, 2'd0, 32'h0, 2'd2);
    check("midcnt_count", dout, 32'd91);
    #1 reset = 1'b1;
    #1 check("async_count", dout, 32'h0);
    check("async_irq", {31'b0, irq}, 32'h0);
    addr = {28'h00007F0, 2'd0};
    #1 check("async_ctrl", dout, 32'h0);
    addr = {28'h00007F0, 2'd1};
    #1 check("async_preset", dout, RP);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 2'd0, 32'h0, 2'd2);
    check("no_resume_count", dout, 32'h0);

    // CTRL write on the INT edge keeps EN and clears the flag
    step(1, 2'd1, 32'd2, 2'd2);
    step(1, 2'd0, 32'h9, 2'd2);
    step(0, 2'd0, 32'h0, 2'd2);
    step(0, 2'd0, 32'h0, 2'd2);
    step(0, 2'd0, 32'h0, 2'd2);
    check("coll_int_irq", {31'b0, irq}, 32'h1);
    step(1, 2'd0, 32'h9, 2'd0);
    check("coll_ctrl", dout, 32'h9);
    check("coll_irq", {31'b0, irq}, 32'h0);
    step(0, 2'd0, 32'h0, 2'd2);
    check("coll_reload", dout, 32'd2);
    step(1, 2'd0, 32'h0, 2'd2);
    step(0, 2'd0, 32'h0, 2'd2);

    // MODE=01 with PRESET=3: periodic pulses if auto-reload is built in, else one held irq
    step(1, 2'd1, 32'd3, 2'd1);
    step(1, 2'd0, 32'hB, 2'd2);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 2'd0, 32'h0, 2'd2);
`ifdef TIMER_AUTORELOAD_EN
      exp_irq = (k == 4) || (k == 9) || (k == 14) || (k == 19);
`else
      exp_irq = (k >= 4);
`endif
      if (irq) pulses++;
      check($sformatf("mode01_irq_e%0d", k), {31'b0, irq}, {31'b0, exp_irq});
    end
    addr = {28'h00007F0, 2'd0};
    #1;
`ifdef TIMER_AUTORELOAD_EN
    check("mode01_pulses", pulses, 32'd4);
    check("mode01_ctrl", dout, 32'hB);
`else
    check("mode01_pulses", pulses, 32'd17);
    check("mode01_ctrl", dout, 32'hA);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
